// File: rtl/prio_arb_pkg.sv
// Shared types and helpers for the batch priority arbiter.
package prio_arb_pkg;

  typedef enum logic {IDLE, SERVE} state_e;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

  // Widest supported request vector is 64; callers cast down to their own width.
  function automatic logic [63:0] onehot_from_idx(input int unsigned idx);
    return 64'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_encode_rot.sv
// Rotatable priority encoder: finds the first set bit of mask scanning down from ptr,
// wrapping from 0 to N-1.
module prio_encode_rot #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found,
  output logic         single
);

  // Walk from lowest to highest priority so the last hit written is the winner.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int p;
      p = int'(ptr) - i;
      if (p < 0) p = p + int'(N);
      if (mask[p]) begin
        idx   = W'(p);
        found = 1'b1;
      end
    end
  end

  assign single = (mask != '0) && ((mask & (mask - 1'b1)) == '0);

endmodule

// File: rtl/priority_encoder_batch_arbiter.sv
// Snapshots a request vector and grants one index per valid/ready handshake,
// in fixed or round-robin priority.
module priority_encoder_batch_arbiter
  import prio_arb_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned RR_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         out_onehot,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned W    = $clog2(N);
  localparam bit          RrEn = (RR_MODE != PRIO_FIXED);

  state_e         state_q, state_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [W-1:0]   ptr_q, ptr_d;

  logic [W-1:0]   grant_idx;
  logic           grant_found;
  logic           grant_single;
  logic [N-1:0]   grant_onehot;

  prio_encode_rot #(
    .N (N),
    .W (W)
  ) u_encode (
    .mask   (mask_q),
    .ptr    (ptr_q),
    .idx    (grant_idx),
    .found  (grant_found),
    .single (grant_single)
  );

  assign grant_onehot = N'(onehot_from_idx(32'(grant_idx)));

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          mask_d  = req;
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (out_ready && grant_found) begin
          mask_d = mask_q & ~grant_onehot;
          if (RrEn) ptr_d = (grant_idx == '0) ? W'(N - 1) : grant_idx - 1'b1;
          // Back-to-back batches: reload on the final accept to avoid a bubble.
          if (grant_single) begin
            if (req != '0) begin
              mask_d = req;
            end else begin
              mask_d  = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      ptr_q   <= W'(N - 1);
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid  = (state_q == SERVE);
  assign busy       = out_valid;
  assign out_idx    = out_valid ? grant_idx : '0;
  assign out_onehot = out_valid ? grant_onehot : '0;
  assign out_last   = out_valid && grant_single;

endmodule

// File: tb/tb_priority_encoder_batch_arbiter.sv
// Bench for the batch arbiter: fixed-priority N=4 and round-robin N=8 instances.
module tb_priority_encoder_batch_arbiter;

  logic       clk = 1'b0;
  logic       rst4, rst8;
  logic [3:0] req4;
  logic [7:0] req8;
  logic       rdy4, rdy8;
  logic       v4, v8, last4, last8, busy4, busy8;
  logic [1:0] idx4;
  logic [2:0] idx8;
  logic [3:0] oh4;
  logic [7:0] oh8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  priority_encoder_batch_arbiter #(.N(4), .RR_MODE(0)) u_dut4 (
    .clk        (clk),
    .rst        (rst4),
    .req        (req4),
    .out_ready  (rdy4),
    .out_valid  (v4),
    .out_idx    (idx4),
    .out_onehot (oh4),
    .out_last   (last4),
    .busy       (busy4)
  );

  priority_encoder_batch_arbiter #(.N(8), .RR_MODE(1)) u_dut8 (
    .clk        (clk),
    .rst        (rst8),
    .req        (req8),
    .out_ready  (rdy8),
    .out_valid  (v8),
    .out_idx    (idx8),
    .out_onehot (oh8),
    .out_last   (last8),
    .busy       (busy8)
  );

  task automatic check(input string name, input logic av, input int ai, input logic [7:0] aoh,
                       input logic al, input logic ab, input logic ev, input int ei,
                       input logic el);
    logic [7:0] eoh;
    int         eidx;
    eoh  = ev ? (8'd1 << ei) : 8'd0;
    eidx = ev ? ei : 0;
    n_checks++;
    if (av !== ev || ai !== eidx || aoh !== eoh || al !== el || ab !== ev) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b idx=%0d onehot=%b last=%0b busy=%0b; want valid=%0b idx=%0d onehot=%b last=%0b busy=%0b",
               name, av, ai, aoh, al, ab, ev, eidx, eoh, el, ev);
    end
  endtask

  task automatic chk4(input string name, input logic ev, input int ei, input logic el);
    check(name, v4, int'(idx4), {4'b0, oh4}, last4, busy4, ev, ei, el);
  endtask

  task automatic chk8(input string name, input logic ev, input int ei, input logic el);
    check(name, v8, int'(idx8), oh8, last8, busy8, ev, ei, el);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset8();
    rst8 = 1'b1;
    req8 = '0;
    rdy8 = 1'b0;
    tick();
    rst8 = 1'b0;
  endtask

  // Reference model: batch as a bit set, pointer as an integer position.
  logic [7:0] m_mask[2];
  int         m_ptr[2];
  bit         m_busy[2];
  int         m_n[2]  = '{4, 8};
  bit         m_rr[2] = '{1'b0, 1'b1};

  function automatic int pick(input logic [7:0] m, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      int pos;
      pos = (p - k + n) % n;
      if (m[pos]) return pos;
    end
    return 0;
  endfunction

  task automatic model_reset(input int i);
    m_mask[i] = '0;
    m_ptr[i]  = m_n[i] - 1;
    m_busy[i] = 1'b0;
  endtask

  task automatic model_expect(input int i, output logic ev, output int ei, output logic el);
    ev = m_busy[i];
    ei = ev ? pick(m_mask[i], m_ptr[i], m_n[i]) : 0;
    el = ev && ($countones(m_mask[i]) == 1);
  endtask

  task automatic model_step(input int i, input logic [7:0] r, input logic rdy);
    int g;
    if (!m_busy[i]) begin
      if (r != 0) begin
        m_mask[i] = r;
        m_busy[i] = 1'b1;
      end
    end else if (rdy) begin
      g = pick(m_mask[i], m_ptr[i], m_n[i]);
      m_mask[i][g] = 1'b0;
      if (m_rr[i]) m_ptr[i] = (g + m_n[i] - 1) % m_n[i];
      if (m_mask[i] == 0) begin
        if (r != 0) m_mask[i] = r;
        else m_busy[i] = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       ev;
    int         ei;
    logic       el;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic ev;
    int   ei;
    logic el;

    // Each row: inputs driven this cycle, outputs expected this cycle.
    for (int i = 0; i < 5; i++) vecs.push_back('{4'b0000, 1'b0, 1'b0, 0, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 1'b0, 0, 1'b0});
    vecs.push_back('{4'b1011, 1'b1, 1'b0, 0, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 1'b1, 3, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 1'b1, 1, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 1'b1, 0, 1'b1});
    vecs.push_back('{4'b0000, 1'b1, 1'b0, 0, 1'b0});
    vecs.push_back('{4'b0101, 1'b0, 1'b0, 0, 1'b0});
    for (int i = 0; i < 3; i++) vecs.push_back('{4'b0000, 1'b0, 1'b1, 2, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 1'b1, 2, 1'b0});
    vecs.push_back('{4'b0000, 1'b1, 1'b1, 0, 1'b1});
    vecs.push_back('{4'b0000, 1'b0, 1'b0, 0, 1'b0});

    rst4 = 1'b1;
    rst8 = 1'b1;
    req4 = '0;
    req8 = '0;
    rdy4 = 1'b0;
    rdy8 = 1'b0;
    tick();
    rst4 = 1'b0;
    rst8 = 1'b0;

    chk8("reset8", 1'b0, 0, 1'b0);
    foreach (vecs[k]) begin
      req4 = vecs[k].req;
      rdy4 = vecs[k].rdy;
      chk4($sformatf("vec4[%0d]", k), vecs[k].ev, vecs[k].ei, vecs[k].el);
      tick();
    end

    // All requests held: full descending sweep then immediate reload.
    req8 = 8'hFF;
    rdy8 = 1'b1;
    chk8("ff_load", 1'b0, 0, 1'b0);
    tick();
    for (int k = 7; k >= 0; k--) begin
      chk8($sformatf("ff_grant%0d", k), 1'b1, k, k == 0);
      tick();
    end
    chk8("ff_nobubble", 1'b1, 7, 1'b0);
    reset8();

    // Two batches of 8'h90: pointer left at 3 still reaches 7 first.
    rdy8 = 1'b1;
    for (int b = 0; b < 2; b++) begin
      req8 = 8'h90;
      chk8($sformatf("b90_load%0d", b), 1'b0, 0, 1'b0);
      tick();
      req8 = 8'h00;
      chk8($sformatf("b90_g7_%0d", b), 1'b1, 7, 1'b0);
      tick();
      chk8($sformatf("b90_g4_%0d", b), 1'b1, 4, 1'b1);
      tick();
    end
    chk8("b90_idle", 1'b0, 0, 1'b0);
    reset8();

    // 8'h80 then 8'h81: pointer at 6 wraps via 0 before 7.
    rdy8 = 1'b1;
    req8 = 8'h80;
    chk8("b80_load", 1'b0, 0, 1'b0);
    tick();
    req8 = 8'h00;
    chk8("b80_g7", 1'b1, 7, 1'b1);
    tick();
    req8 = 8'h81;
    chk8("b81_load", 1'b0, 0, 1'b0);
    tick();
    req8 = 8'h00;
    chk8("b81_g0", 1'b1, 0, 1'b0);
    tick();
    chk8("b81_g7", 1'b1, 7, 1'b1);
    tick();
    chk8("b81_idle", 1'b0, 0, 1'b0);
    reset8();

    // Asynchronous reset mid-batch.
    rdy8 = 1'b1;
    req8 = 8'h0F;
    chk8("mid_load", 1'b0, 0, 1'b0);
    tick();
    chk8("mid_g3", 1'b1, 3, 1'b0);
    tick();
    #2;
    rst8 = 1'b1;
    #1;
    chk8("mid_async", 1'b0, 0, 1'b0);
    req8 = 8'h00;
    tick();
    rst8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk8($sformatf("mid_idle%0d", k), 1'b0, 0, 1'b0);
      tick();
    end
    // Pointer must be back at 7: batch 8'h88 grants 7 before 3.
    req8 = 8'h88;
    chk8("mid_reload", 1'b0, 0, 1'b0);
    tick();
    req8 = 8'h00;
    chk8("mid_ptr7", 1'b1, 7, 1'b0);
    tick();
    chk8("mid_g3b", 1'b1, 3, 1'b1);
    tick();
    chk8("mid_done", 1'b0, 0, 1'b0);

    // Randomized traffic on both instances against the model.
    rst4 = 1'b1;
    rst8 = 1'b1;
    req4 = '0;
    req8 = '0;
    rdy4 = 1'b0;
    rdy8 = 1'b0;
    tick();
    rst4 = 1'b0;
    rst8 = 1'b0;
    model_reset(0);
    model_reset(1);
    for (int c = 0; c < 600; c++) begin
      req4 = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      req8 = ($urandom_range(0, 2) == 0) ? 8'h0 : 8'($urandom);
      rdy4 = ($urandom_range(0, 3) != 0);
      rdy8 = ($urandom_range(0, 3) != 0);
      model_expect(0, ev, ei, el);
      chk4($sformatf("rand4[%0d]", c), ev, ei, el);
      model_expect(1, ev, ei, el);
      chk8($sformatf("rand8[%0d]", c), ev, ei, el);
      tick();
      model_step(0, {4'b0, req4}, rdy4);
      model_step(1, req8, rdy8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
